// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 Hz timing defaults, the raster coordinate type and a
// helper that turns porch/sync widths into an inclusive sync-pulse window.
package vga_pkg;

  // Default horizontal timing, in pixel clocks
  localparam int unsigned HVisible = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned HTotal   = HVisible + HFront + HSync + HBack;

  // Default vertical timing, in lines
  localparam int unsigned VVisible = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;
  localparam int unsigned VTotal   = VVisible + VFront + VSync + VBack;

  typedef logic [9:0] vga_coord_t;

  // Inclusive counter range during which a sync is driven low
  typedef struct packed {
    vga_coord_t first;
    vga_coord_t last;
  } sync_win_t;

  function automatic sync_win_t sync_window(input int unsigned visible,
                                            input int unsigned front,
                                            input int unsigned sync);
    sync_win_t win;
    win.first = vga_coord_t'(visible + front);
    win.last  = vga_coord_t'(visible + front + sync - 1);
    return win;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the generator to the pixel stages.
//   hs, vs       - active-low syncs (already delayed to match registered RGB)
//   blank        - 1 on a drawable pixel
//   DrawX, DrawY - current horizontal / vertical counter
//   line_start   - pulse at DrawX==0
//   frame_start  - pulse at DrawX==0 and DrawY==0
// master: generator side (drives everything); slave: consumer side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       hs;
  logic       vs;
  logic       blank;
  vga_coord_t DrawX;
  vga_coord_t DrawY;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hs, vs, blank, DrawX, DrawY, line_start, frame_start
  );

  modport slave (
    input hs, vs, blank, DrawX, DrawY, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-stage shift register for an active-low sync. Every stage resets
// to 1 so the delayed sync is inactive straight out of reset. N=0 is a wire.
//   vga_clk - pixel clock
//   reset_n - synchronous active-low reset
//   i_d     - raw sync in
//   o_q     - sync delayed by N cycles
module vga_sync_delay #(
  parameter int unsigned N = 1
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  if (N == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = vga_clk ^ reset_n;
    assign o_q = i_d;
  end else begin : g_pipe
    logic [N-1:0] r_stage;

    always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
        r_stage <= '1;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < int'(N); i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign o_q = r_stage[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
//   vga_clk - pixel clock, all logic on posedge
//   reset_n - synchronous active-low reset
//   o_vga   - timing bundle (master modport): hs/vs (delayed SYNC_DELAY cycles),
//             blank, DrawX, DrawY, line_start, frame_start (all undelayed)
// Totals must fit the 10-bit counters; SYNC_DELAY is intended for 0..4.
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_VISIBLE  = HVisible,
  parameter int unsigned H_FRONT    = HFront,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BACK     = HBack,
  parameter int unsigned V_VISIBLE  = VVisible,
  parameter int unsigned V_FRONT    = VFront,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BACK     = VBack,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  o_vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam vga_coord_t HLast = vga_coord_t'(H_TOTAL - 1);
  localparam vga_coord_t VLast = vga_coord_t'(V_TOTAL - 1);
  localparam vga_coord_t HVis  = vga_coord_t'(H_VISIBLE);
  localparam vga_coord_t VVis  = vga_coord_t'(V_VISIBLE);

  localparam sync_win_t HWin = sync_window(H_VISIBLE, H_FRONT, H_SYNC);
  localparam sync_win_t VWin = sync_window(V_VISIBLE, V_FRONT, V_SYNC);

  logic       r_active;
  vga_coord_t r_hc, r_vc;
  vga_coord_t w_hc_d, w_vc_d;
  logic       w_hs_raw, w_vs_raw;

  // Counters hold while inactive, so the release edge only sets r_active and the
  // first visible pixel (0,0) is presented for a full cycle.
  always_comb begin
    w_hc_d = r_hc;
    w_vc_d = r_vc;
    if (r_active) begin
      if (r_hc == HLast) begin
        w_hc_d = '0;
        w_vc_d = (r_vc == VLast) ? '0 : r_vc + 10'd1;
      end else begin
        w_hc_d = r_hc + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_hc     <= '0;
      r_vc     <= '0;
    end else begin
      r_active <= 1'b1;
      r_hc     <= w_hc_d;
      r_vc     <= w_vc_d;
    end
  end

  assign w_hs_raw = ~(r_active & (r_hc >= HWin.first) & (r_hc <= HWin.last));
  assign w_vs_raw = ~(r_active & (r_vc >= VWin.first) & (r_vc <= VWin.last));

  // Syncs are delayed to line up with the RGB registered downstream
  vga_sync_delay #(
    .N (SYNC_DELAY)
  ) u_hs_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .i_d     (w_hs_raw),
    .o_q     (o_vga.hs)
  );

  vga_sync_delay #(
    .N (SYNC_DELAY)
  ) u_vs_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .i_d     (w_vs_raw),
    .o_q     (o_vga.vs)
  );

  assign o_vga.DrawX       = r_hc;
  assign o_vga.DrawY       = r_vc;
  assign o_vga.blank       = r_active & (r_hc < HVis) & (r_vc < VVis);
  assign o_vga.line_start  = r_active & (r_hc == '0);
  assign o_vga.frame_start = r_active & (r_hc == '0) & (r_vc == '0);

endmodule
